am2910_ctl: RTL and testbench

- Microprogram controller: the front end that feeds the am2910 sequencer.
- Takes the sequencer's Y address and fetches the microword from an internal writable control store into a pipeline register.
- Decodes that microword into the sequencer inputs I, CCEN_BAR, CC_BAR, RLD_BAR and CI.
- Drives the sequencer D bus from one of three sources, chosen by the sequencer's select strobes: pipeline branch field, opcode map table, or latched interrupt vector.

---
 rtl/am2910_ctl.sv | 135 +++++++++++++
 tb/tb_am2910_ctl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/am2910_ctl.sv
// Microprogram front end for the am2910 sequencer: writable control store, pipeline
// register, instruction decode, D-bus source mux and interrupt vector latch.
// Optional microword parity checking is enabled by defining AM2910_CTL_PARITY_EN.
module am2910_ctl #(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [11:0]   Y,
    input  logic          pl_bar,
    input  logic          map_bar,
    input  logic          vect_bar,
    input  logic [3:0]    opcode,
    input  logic [7:0]    cond_in,
    input  logic          stall,
    input  logic          cs_we,
    input  logic [AW-1:0] cs_waddr,
    input  logic [24:0]   cs_wdata,
    input  logic          map_we,
    input  logic [3:0]    map_waddr,
    input  logic [11:0]   map_wdata,
    input  logic          irq_valid,
    input  logic [11:0]   irq_vec,
    output logic          irq_ready,
    output logic          irq_ack,
    output logic [3:0]    I,
    output logic          CCEN_BAR,
    output logic          CC_BAR,
    output logic          RLD_BAR,
    output logic          CI,
    output logic [11:0]   D,
    output logic          par_err
);
    localparam int unsigned DEPTH    = 1 << AW;
    localparam int unsigned MAP_N    = 16;
    localparam logic [24:0] RST_WORD = 25'h1000610;

    logic [24:0] cs_mem [DEPTH];
    logic [24:0] rd_word;
    logic [24:0] load_word;
    logic [24:0] pr;
    logic [11:0] map_q [MAP_N];
    logic [11:0] vec_q;
    logic        pending;
    logic        ack_q;

    // Control store: not reset; read path samples the old word on a same-address write
    always_ff @(posedge clk) begin
        if (cs_we) cs_mem[cs_waddr] <= cs_wdata;
    end

    assign rd_word = cs_mem[Y[AW-1:0]];

`ifdef AM2910_CTL_PARITY_EN
    // A word failing even parity is replaced by CONT so the sequencer simply holds
    localparam logic [24:0] CONT_WORD = 25'h100021E;
    logic par_bad;
    logic par_q;

    assign par_bad   = ^rd_word;
    assign load_word = par_bad ? CONT_WORD : rd_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 par_q <= 1'b0;
        else if (!stall && par_bad) par_q <= 1'b1;
    end

    assign par_err = par_q;
`else
    assign load_word = rd_word;
    assign par_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pr <= RST_WORD;
        else if (!stall) pr <= load_word;
    end

    // Decode, with stall forcing CONT so the sequencer re-issues the same Y
    always_comb begin
        I        = pr[3:0];
        CCEN_BAR = pr[4];
        RLD_BAR  = pr[9];
        CI       = pr[10];
        if (stall) begin
            I        = 4'd14;
            CCEN_BAR = 1'b1;
            RLD_BAR  = 1'b1;
            CI       = 1'b0;
        end
    end

    assign CC_BAR = ~(cond_in[pr[7:5]] ^ pr[8]);

    always_comb begin
        D = 12'd0;
        if (vect_bar)     D = pending ? vec_q : 12'd0;
        else if (map_bar) D = map_q[opcode];
        else if (!pl_bar) D = pr[22:11];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(MAP_N); k++) map_q[k] <= 12'd0;
        end else if (map_we) begin
            map_q[map_waddr] <= map_wdata;
        end
    end

    // Single-entry vector latch; a consumed slot accepts a new offer one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            ack_q   <= 1'b0;
            vec_q   <= 12'd0;
        end else begin
            ack_q <= 1'b0;
            if (pending) begin
                if (vect_bar && !stall) begin
                    pending <= 1'b0;
                    ack_q   <= 1'b1;
                end
            end else if (irq_valid) begin
                vec_q   <= irq_vec;
                pending <= 1'b1;
            end
        end
    end

    assign irq_ready = ~pending;
    assign irq_ack   = ack_q;

    logic unused_bits;
    assign unused_bits = ^{Y[11:AW], pr[24:23]};
endmodule

// File: tb/tb_am2910_ctl.sv
// Directed bench for am2910_ctl: expected values are queued when stimulus is driven
// and popped when the DUT outputs are sampled (1 ns after the rising edge or input change).
module tb_am2910_ctl;
    localparam int unsigned AW = 8;

    logic          clk;
    logic          rst_n;
    logic [11:0]   Y;
    logic          pl_bar, map_bar, vect_bar;
    logic [3:0]    opcode;
    logic [7:0]    cond_in;
    logic          stall;
    logic          cs_we;
    logic [AW-1:0] cs_waddr;
    logic [24:0]   cs_wdata;
    logic          map_we;
    logic [3:0]    map_waddr;
    logic [11:0]   map_wdata;
    logic          irq_valid;
    logic [11:0]   irq_vec;
    logic          irq_ready, irq_ack;
    logic [3:0]    I;
    logic          CCEN_BAR, CC_BAR, RLD_BAR, CI;
    logic [11:0]   D;
    logic          par_err;

    am2910_ctl #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .Y(Y), .pl_bar(pl_bar), .map_bar(map_bar),
        .vect_bar(vect_bar), .opcode(opcode), .cond_in(cond_in), .stall(stall),
        .cs_we(cs_we), .cs_waddr(cs_waddr), .cs_wdata(cs_wdata),
        .map_we(map_we), .map_waddr(map_waddr), .map_wdata(map_wdata),
        .irq_valid(irq_valid), .irq_vec(irq_vec), .irq_ready(irq_ready),
        .irq_ack(irq_ack), .I(I), .CCEN_BAR(CCEN_BAR), .CC_BAR(CC_BAR),
        .RLD_BAR(RLD_BAR), .CI(CI), .D(D), .par_err(par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    string       sb_tag[$];
    logic [31:0] sb_exp[$];

    function automatic logic [24:0] mk_word(input logic [3:0] i, input logic ccen,
                                            input logic [2:0] csel, input logic cpol,
                                            input logic rld, input logic ci,
                                            input logic [11:0] br);
        logic [23:0] w;
        w = {1'b0, br, ci, rld, cpol, csel, ccen, i};
        return {^w, w};
    endfunction

    task automatic sb_push(input string tag, input logic [31:0] v);
        sb_tag.push_back(tag);
        sb_exp.push_back(v);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        string       tag;
        logic [31:0] ex;
        n_tests++;
        if (sb_exp.size() == 0) begin
            n_fail++;
            $error("FAIL sb_underflow: observed %h expected <none>", obs);
            return;
        end
        tag = sb_tag.pop_front();
        ex  = sb_exp.pop_front();
        assert (obs === ex) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, ex);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cs_write(input logic [AW-1:0] a, input logic [24:0] d);
        cs_we = 1'b1; cs_waddr = a; cs_wdata = d;
        tick();
        cs_we = 1'b0;
    endtask

    logic [24:0] w5, w9a, w9b, w9c, wbad;

    initial begin
        rst_n = 1'b0; Y = 12'd0; pl_bar = 1'b1; map_bar = 1'b0; vect_bar = 1'b0;
        opcode = 4'd0; cond_in = 8'd0; stall = 1'b0; cs_we = 1'b0; cs_waddr = '0;
        cs_wdata = 25'd0; map_we = 1'b0; map_waddr = 4'd0; map_wdata = 12'd0;
        irq_valid = 1'b0; irq_vec = 12'd0;

        w5   = mk_word(4'd3, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 12'h0A5);
        w9a  = mk_word(4'd10, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 12'h111);
        w9b  = mk_word(4'd10, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 12'h222);
        w9c  = mk_word(4'd10, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 12'h333);
        wbad = mk_word(4'd5, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 12'h0AB) ^ 25'h1000000;

        // Load the control store while reset holds the pipeline register
        tick();
        cs_write(8'd0, mk_word(4'd0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 12'h000));
        cs_write(8'd5, w5);
        cs_write(8'd9, w9a);
        cs_write(8'd3, wbad);

        // Reset state, strobes idle
        rst_n = 1'b1;
        sb_push("rst_I", 32'd0); sb_push("rst_ccen", 32'd1); sb_push("rst_rld", 32'd1);
        sb_push("rst_ci", 32'd1); sb_push("rst_D", 32'd0); sb_push("rst_ready", 32'd1);
        sb_push("rst_ack", 32'd0); sb_push("rst_par", 32'd0);
        #1;
        sb_check(32'(I)); sb_check(32'(CCEN_BAR)); sb_check(32'(RLD_BAR));
        sb_check(32'(CI)); sb_check(32'(D)); sb_check(32'(irq_ready));
        sb_check(32'(irq_ack)); sb_check(32'(par_err));

        // Fetch latency, branch field on D, condition polarity
        Y = 12'd5; pl_bar = 1'b0; cond_in = 8'h04;
        sb_push("fetch_I", 32'd3); sb_push("fetch_D", 32'h0A5);
        sb_push("fetch_ccen", 32'd0); sb_push("cc_hi", 32'd1);
        tick();
        sb_check(32'(I)); sb_check(32'(D)); sb_check(32'(CCEN_BAR)); sb_check(32'(CC_BAR));
        cond_in = 8'hFB;
        sb_push("cc_lo", 32'd0);
        #1; sb_check(32'(CC_BAR));

        // Map table read overrides the pipeline source
        map_we = 1'b1; map_waddr = 4'h7; map_wdata = 12'h3C0;
        tick();
        map_we = 1'b0; opcode = 4'h7; map_bar = 1'b1;
        sb_push("map_D", 32'h3C0);
        #1; sb_check(32'(D));
        map_bar = 1'b0; pl_bar = 1'b1;
        sb_push("idle_D", 32'd0);
        #1; sb_check(32'(D));

        // Interrupt handshake with an overlapping second offer
        irq_vec = 12'h800; irq_valid = 1'b1;
        sb_push("irq_ready0", 32'd1);
        #1; sb_check(32'(irq_ready));
        tick();
        irq_valid = 1'b0;
        sb_push("irq_ready1", 32'd0);
        sb_check(32'(irq_ready));
        vect_bar = 1'b1;
        sb_push("vec_D", 32'h800);
        #1; sb_check(32'(D));
        irq_vec = 12'h801; irq_valid = 1'b1;
        sb_push("ack_pulse", 32'd1); sb_push("ready_after_ack", 32'd1); sb_push("vec_empty_D", 32'd0);
        tick();
        sb_check(32'(irq_ack)); sb_check(32'(irq_ready)); sb_check(32'(D));
        vect_bar = 1'b0;
        sb_push("ack_drop", 32'd0); sb_push("second_taken", 32'd0);
        tick();
        sb_check(32'(irq_ack)); sb_check(32'(irq_ready));
        irq_valid = 1'b0; vect_bar = 1'b1; stall = 1'b1;
        sb_push("vec2_D", 32'h801);
        #1; sb_check(32'(D));
        sb_push("stall_no_consume", 32'd0); sb_push("stall_no_ack", 32'd0);
        tick();
        sb_check(32'(irq_ready)); sb_check(32'(irq_ack));
        stall = 1'b0;
        sb_push("ack2_pulse", 32'd1); sb_push("ready2", 32'd1);
        tick();
        sb_check(32'(irq_ack)); sb_check(32'(irq_ready));
        vect_bar = 1'b0;
        sb_push("ack2_drop", 32'd0);
        tick();
        sb_check(32'(irq_ack));

        // Stall for three cycles with a store write to the held address
        Y = 12'd9; pl_bar = 1'b0;
        sb_push("pre_stall_I", 32'd10); sb_push("pre_stall_D", 32'h111);
        tick();
        sb_check(32'(I)); sb_check(32'(D));
        stall = 1'b1;
        sb_push("stall1_I", 32'd14); sb_push("stall1_ci", 32'd0);
        sb_push("stall1_ccen", 32'd1); sb_push("stall1_rld", 32'd1);
        #1;
        sb_check(32'(I)); sb_check(32'(CI)); sb_check(32'(CCEN_BAR)); sb_check(32'(RLD_BAR));
        sb_push("stall2_I", 32'd14); sb_push("stall2_D", 32'h111);
        cs_write(8'd9, w9b);
        sb_check(32'(I)); sb_check(32'(D));
        sb_push("stall3_I", 32'd14); sb_push("stall3_ci", 32'd0);
        tick();
        sb_check(32'(I)); sb_check(32'(CI));
        stall = 1'b0;
        sb_push("release_I", 32'd10); sb_push("release_D", 32'h111); sb_push("release_ci", 32'd1);
        #1; sb_check(32'(I)); sb_check(32'(D)); sb_check(32'(CI));
        sb_push("stall_write_seen", 32'h222);
        tick();
        sb_check(32'(D));

        // Same-address read and write: the pipeline sees the old word first
        cs_we = 1'b1; cs_waddr = 8'd9; cs_wdata = w9c;
        sb_push("rbw_old", 32'h222);
        tick();
        cs_we = 1'b0;
        sb_check(32'(D));
        sb_push("rbw_new", 32'h333);
        tick();
        sb_check(32'(D));

        // Fetch of a word with bad parity
        Y = 12'd3;
`ifdef AM2910_CTL_PARITY_EN
        sb_push("par_I", 32'd14); sb_push("par_ci", 32'd0);
        sb_push("par_err_set", 32'd1); sb_push("par_D", 32'd0);
        tick();
        sb_check(32'(I)); sb_check(32'(CI)); sb_check(32'(par_err)); sb_check(32'(D));
        Y = 12'd5;
        sb_push("par_good_I", 32'd3); sb_push("par_sticky", 32'd1);
        tick();
        sb_check(32'(I)); sb_check(32'(par_err));
`else
        sb_push("nopar_I", 32'd5); sb_push("nopar_D", 32'h0AB); sb_push("nopar_err", 32'd0);
        tick();
        sb_check(32'(I)); sb_check(32'(D)); sb_check(32'(par_err));
        Y = 12'd5;
        sb_push("nopar_next_I", 32'd3);
        tick();
        sb_check(32'(I));
`endif

        // Asynchronous reset mid-stall with a vector pending
        irq_vec = 12'h123; irq_valid = 1'b1;
        tick();
        irq_valid = 1'b0; stall = 1'b1;
        #2;
        rst_n = 1'b0;
        sb_push("arst_ready", 32'd1); sb_push("arst_ack", 32'd0);
        sb_push("arst_par", 32'd0); sb_push("arst_stall_I", 32'd14);
        #1;
        sb_check(32'(irq_ready)); sb_check(32'(irq_ack)); sb_check(32'(par_err)); sb_check(32'(I));
        stall = 1'b0; pl_bar = 1'b1;
        sb_push("arst_I", 32'd0); sb_push("arst_ci", 32'd1);
        sb_push("arst_rld", 32'd1); sb_push("arst_D", 32'd0);
        #1;
        sb_check(32'(I)); sb_check(32'(CI)); sb_check(32'(RLD_BAR)); sb_check(32'(D));
        map_bar = 1'b1; opcode = 4'h7;
        sb_push("map_cleared", 32'd0);
        #1; sb_check(32'(D));
        map_bar = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        if (sb_exp.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL sb_leftover: observed %0d entries expected 0", sb_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
